// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
// Pattern width limits, fill-counter sizing and detection mode labels.
package seq_det_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 32;

    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } mode_e;

    // fill counts up to pat_w-1, which always fits in clog2(pat_w) bits
    function automatic int fill_width(input int pat_w);
        return (pat_w <= 2) ? 1 : $clog2(pat_w);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear is applied first, so clr and inc together yield a count of one.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] base;
    logic [W-1:0] count_nxt;

    always_comb begin
        base      = clr ? '0 : count;
        count_nxt = base;
        if (inc && (base != '1)) begin
            count_nxt = base + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with Mealy match output,
// runtime-loadable pattern, overlap control and saturating match count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b1010,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             match,
    output logic             match_r,
    output logic [CNT_W-1:0] match_count,
    output logic [PAT_W-1:0] pattern
);

    localparam int             FW       = fill_width(PAT_W);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("PAT_W out of range");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("CNT_W out of range");
    end

    logic [PAT_W-2:0] hist;
    logic [PAT_W-2:0] hist_nxt;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nxt;
    logic [PAT_W-1:0] window;

    assign window = {hist, in_bit};

    always_comb begin
        match    = in_valid & ~pat_load & (fill == FILL_MAX)
                 & (window == pattern);
        hist_nxt = hist;
        fill_nxt = fill;
        if (pat_load) begin
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (in_valid) begin
            // non-overlap restarts so no matched bit is reused
            if (match && !overlap_en) begin
                hist_nxt = '0;
                fill_nxt = '0;
            end else begin
                hist_nxt = window[PAT_W-2:0];
                fill_nxt = (fill == FILL_MAX) ? fill : fill + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist    <= '0;
            fill    <= '0;
            pattern <= PAT_DEFAULT;
            match_r <= 1'b0;
        end else begin
            hist    <= hist_nxt;
            fill    <= fill_nxt;
            match_r <= match;
            if (pat_load) begin
                pattern <= pat_in;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match),
        .clr   (cnt_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: vector table, directed corner cases and
// random stimulus against a queue-based model of the detection rules.
module tb_seq_detector_param;

    localparam int PW   = 4;
    localparam int CW   = 8;
    localparam int CW2  = 2;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int CMAX2 = (1 << CW2) - 1;
    localparam logic [PW-1:0] PDEF = 4'b1010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic          overlap_en = 1'b0;
    logic          pat_load = 1'b0;
    logic [PW-1:0] pat_in = '0;
    logic          cnt_clr = 1'b0;

    logic           match, match_r, match2, match_r2;
    logic [CW-1:0]  match_count;
    logic [CW2-1:0] match_count2;
    logic [PW-1:0]  pattern, pattern2;

    int cmp_n = 0;
    int err_n = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(PW), .PAT_DEFAULT(PDEF), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .match(match), .match_r(match_r),
        .match_count(match_count), .pattern(pattern)
    );

    seq_detector_param #(.PAT_W(PW), .PAT_DEFAULT(PDEF), .CNT_W(CW2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .match(match2), .match_r(match_r2),
        .match_count(match_count2), .pattern(pattern2)
    );

    // model: accepted bits since last restart, oldest first
    bit            hq[$];
    logic [PW-1:0] mpat = PDEF;
    int            mcnt = 0;
    int            mcnt2 = 0;
    logic          mr = 1'b0;

    function automatic logic exp_match(input logic v, input logic b,
                                       input logic ld);
        logic [PW-1:0] w;
        if (!v || ld || hq.size() < PW - 1) return 1'b0;
        for (int i = 0; i < PW - 1; i++) w[PW-1-i] = hq[i];
        w[0] = b;
        return w == mpat;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // entered and left at posedge+1
    task automatic cycle(input logic v, input logic b, input logic ov,
                         input logic ld, input logic [PW-1:0] pi,
                         input logic clr, output logic seen);
        logic m;
        in_valid = v; in_bit = b; overlap_en = ov;
        pat_load = ld; pat_in = pi; cnt_clr = clr;
        m = exp_match(v, b, ld);
        #3;
        seen = match;
        check("match", match, m);
        check("match_cw2", match2, m);
        @(posedge clk);
        #1;
        if (ld) begin
            mpat = pi;
            hq.delete();
        end else if (v) begin
            if (m && !ov) begin
                hq.delete();
            end else begin
                hq.push_back(b);
                if (hq.size() > PW - 1) void'(hq.pop_front());
            end
        end
        if (clr) begin
            mcnt = 0;
            mcnt2 = 0;
        end
        if (m) begin
            if (mcnt < CMAX) mcnt++;
            if (mcnt2 < CMAX2) mcnt2++;
        end
        mr = m;
        check("match_r", match_r, mr);
        check("match_count", match_count, mcnt);
        check("match_count_cw2", match_count2, mcnt2);
        check("pattern", pattern, mpat);
    endtask

    task automatic bit_in(input logic b, input logic ov, output logic s);
        cycle(1'b1, b, ov, 1'b0, '0, 1'b0, s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
        #1;
        check("rst_match_r", match_r, 0);
        check("rst_match", match, 0);
        check("rst_count", match_count, 0);
        check("rst_count_cw2", match_count2, 0);
        check("rst_pattern", pattern, PDEF);
        hq.delete();
        mpat = PDEF; mcnt = 0; mcnt2 = 0; mr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic v;
        logic b;
        logic ov;
        logic em;
        int   ecnt;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic       s;
        int         nm;
        logic [7:0] stream = 8'b10101010;
        logic [7:0] em_no  = 8'b00010001;
        logic [7:0] em_ov  = 8'b00010101;
        int         ecnt[16] = '{0, 0, 0, 1, 1, 1, 1, 2,
                                 2, 2, 2, 3, 3, 4, 4, 5};

        for (int i = 0; i < 16; i++) begin
            tbl[i].v    = 1'b1;
            tbl[i].b    = stream[7 - (i % 8)];
            tbl[i].ov   = (i >= 8);
            tbl[i].em   = (i < 8) ? em_no[7 - i] : em_ov[7 - (i - 8)];
            tbl[i].ecnt = ecnt[i];
        end

        @(posedge clk);
        #1;
        do_reset();

        // plan 1 and 2 from the vector table
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].v, tbl[i].b, tbl[i].ov, 1'b0, '0, 1'b0, s);
            check($sformatf("tbl_match[%0d]", i), s, tbl[i].em);
            check($sformatf("tbl_count[%0d]", i), match_count, tbl[i].ecnt);
        end

        // plan 3: gap in valid holds progress
        do_reset();
        bit_in(1'b1, 1'b0, s);
        bit_in(1'b0, 1'b0, s);
        bit_in(1'b1, 1'b0, s);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, s);
            check("gap_match", s, 0);
        end
        bit_in(1'b0, 1'b0, s);
        check("gap_final_match", s, 1);

        // plan 4: load discards partial history
        do_reset();
        bit_in(1'b0, 1'b0, s);
        bit_in(1'b1, 1'b0, s);
        bit_in(1'b1, 1'b0, s);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, s);
        check("load_match", s, 0);
        check("load_pattern", pattern, 4'b0110);
        nm = 0;
        bit_in(1'b0, 1'b0, s); nm += int'(s);
        bit_in(1'b1, 1'b0, s); nm += int'(s);
        bit_in(1'b1, 1'b0, s); nm += int'(s);
        bit_in(1'b0, 1'b0, s); nm += int'(s);
        check("load_last_match", s, 1);
        check("load_num_matches", nm, 1);

        // plan 5: saturation of the 2-bit counter, clear with match
        do_reset();
        for (int i = 0; i < 14; i++) bit_in(stream[7 - (i % 8)], 1'b1, s);
        check("sat_count_cw2", match_count2, 3);
        check("sat_count", match_count, 6);
        bit_in(1'b1, 1'b1, s);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, s);
        check("clr_match", s, 1);
        check("clr_count_cw2", match_count2, 1);
        check("clr_count", match_count, 1);

        // plan 6: async reset mid-sequence
        do_reset();
        bit_in(1'b1, 1'b0, s);
        bit_in(1'b0, 1'b0, s);
        bit_in(1'b1, 1'b0, s);
        bit_in(1'b0, 1'b0, s);
        check("pre_rst_match_r", match_r, 1);
        do_reset();
        bit_in(1'b1, 1'b0, s);
        bit_in(1'b0, 1'b0, s);
        bit_in(1'b1, 1'b0, s);
        do_reset();
        bit_in(1'b0, 1'b0, s);
        check("post_rst_match", s, 0);
        check("post_rst_pattern", pattern, PDEF);

        // random stimulus against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic          ld;
            logic [PW-1:0] pi;
            ld = ($urandom_range(0, 49) == 0);
            pi = ($urandom_range(0, 3) == 0) ? '1 : PW'($urandom);
            cycle(($urandom_range(0, 3) != 0), 1'($urandom),
                  ($urandom_range(0, 7) != 0), ld, pi,
                  ($urandom_range(0, 99) == 0), s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_n, err_n);
        $finish;
    end

endmodule
